// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit: the carry chain is cut into STAGES
// registered segments, with a valid/ready handshake and a single global stall.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);
    localparam int SEG = WIDTH / STAGES;

    // acc holds finished sum slices below the stage's segment and raw A above it;
    // b holds the effective (possibly inverted) B operand travelling alongside.
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] acc_q [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic             ovf_q;

    logic             v_d   [STAGES];
    logic             c_d   [STAGES];
    logic [WIDTH-1:0] acc_d [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic             ovf_d;

    logic             en;

    function automatic logic [SEG:0] seg_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             c,
                                             input int               k);
        return {1'b0, x[k*SEG +: SEG]} + {1'b0, y[k*SEG +: SEG]} + {{SEG{1'b0}}, c};
    endfunction

    assign en         = ~v_q[STAGES-1] | out_ready_i;
    assign in_ready_o = en & ~rst_i;

    // Overflow is rewritten by every stage; only the last stage's value, which
    // covers bit WIDTH-1, survives the loop.
    always_comb begin
        logic [WIDTH-1:0] src_b;
        logic [SEG:0]     seg;

        src_b    = sub_i ? ~b_i : b_i;
        seg      = seg_add(a_i, src_b, sub_i ^ carry_i, 0);
        v_d[0]   = in_valid_i;
        c_d[0]   = seg[SEG];
        b_d[0]   = src_b;
        acc_d[0] = a_i;
        acc_d[0][SEG-1:0] = seg[SEG-1:0];
        ovf_d    = seg[SEG] ^ a_i[WIDTH-1] ^ src_b[WIDTH-1] ^ seg[SEG-1];

        for (int k = 1; k < STAGES; k++) begin
            seg      = seg_add(acc_q[k-1], b_q[k-1], c_q[k-1], k);
            v_d[k]   = v_q[k-1];
            c_d[k]   = seg[SEG];
            b_d[k]   = b_q[k-1];
            acc_d[k] = acc_q[k-1];
            acc_d[k][k*SEG +: SEG] = seg[SEG-1:0];
            ovf_d    = seg[SEG] ^ acc_q[k-1][WIDTH-1] ^ b_q[k-1][WIDTH-1] ^ seg[SEG-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                c_q[k]   <= c_d[k];
                acc_q[k] <= acc_d[k];
                b_q[k]   <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid_o = v_q[STAGES-1];
    assign sum_o       = acc_q[STAGES-1];
    assign carry_o     = c_q[STAGES-1];
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, backpressure
// stream, mid-flight reset and a parameter sweep over STAGES and WIDTH.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Main instance, WIDTH=32, STAGES=4
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .sub_i(sub), .carry_i(cin),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum_o(sum), .carry_o(cout), .overflow_o(ovf)
    );

    // Sweep instances share one always-ready input stream
    localparam int SW [4] = '{1, 2, 8, 32};
    logic        sw_valid, sw_sub, sw_cin, sw_ready;
    logic [31:0] sw_a, sw_b;
    logic [31:0] sw_sum [4];
    logic        sw_c   [4];
    logic        sw_ov  [4];
    logic        sw_v   [4];
    logic        sw_inr [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        pipelined_adder #(.WIDTH(32), .STAGES(SW[g])) u_sw (
            .clk_i(clk), .rst_i(rst), .in_valid_i(sw_valid), .in_ready_o(sw_inr[g]),
            .a_i(sw_a), .b_i(sw_b), .sub_i(sw_sub), .carry_i(sw_cin),
            .out_valid_o(sw_v[g]), .out_ready_i(sw_ready),
            .sum_o(sw_sum[g]), .carry_o(sw_c[g]), .overflow_o(sw_ov[g])
        );
    end

    logic [7:0] w8_sum;
    logic       w8_c, w8_ov, w8_v, w8_inr;

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_w8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(sw_valid), .in_ready_o(w8_inr),
        .a_i(sw_a[7:0]), .b_i(sw_b[7:0]), .sub_i(sw_sub), .carry_i(sw_cin),
        .out_valid_o(w8_v), .out_ready_i(sw_ready),
        .sum_o(w8_sum), .carry_o(w8_c), .overflow_o(w8_ov)
    );

    // Reference: overflow taken from operand/result signs, not from carries
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic c);
        logic [31:0] yy;
        logic [32:0] full;
        logic        v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, s ? ~c : c};
        v    = (x[31] == yy[31]) && (full[31] != x[31]);
        return {v, full[32], full[31:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic s, input logic c);
        logic [7:0] yy;
        logic [8:0] full;
        logic       v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'd0, s ? ~c : c};
        v    = (x[7] == yy[7]) && (full[7] != x[7]);
        return {v, full[8], full[7:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present one operation with the consumer ready and wait for its result
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic ts, input logic tc, output int lat);
        a         = ta;
        b         = tb;
        sub       = ts;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        c;
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    localparam int NV  = 10;
    localparam int NST = 20;
    localparam int NSW = 40;

    vec_t        vecs [NV];
    logic [31:0] sa [NST], sb [NST];
    logic        ss [NST], sc [NST];
    logic [33:0] sexp [NST];
    logic [31:0] pa [NSW], pb [NSW];
    logic        ps [NSW], pc [NSW];

    initial begin
        int          lat, sent, got, cyc, extra, idx;
        logic        stalled, expv;
        logic [34:0] held;

        total = 0;  bad = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_cin = 1'b0;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

        for (int i = 0; i < NST; i++) begin
            sa[i]   = $urandom();
            sb[i]   = $urandom();
            ss[i]   = 1'($urandom_range(0, 1));
            sc[i]   = 1'($urandom_range(0, 1));
            sexp[i] = model32(sa[i], sb[i], ss[i], sc[i]);
        end
        for (int i = 0; i < NSW; i++) begin
            pa[i] = $urandom();
            pb[i] = $urandom();
            ps[i] = 1'($urandom_range(0, 1));
            pc[i] = 1'($urandom_range(0, 1));
        end
        pa[0] = 32'hFFFF_FFFF; pb[0] = 32'h0; ps[0] = 1'b0; pc[0] = 1'b1;
        pa[1] = 32'h7FFF_FF7F; pb[1] = 32'h1;  ps[1] = 1'b0; pc[1] = 1'b0;
        pa[2] = 32'h8000_0080; pb[2] = 32'h1;  ps[2] = 1'b1; pc[2] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_carry", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", in_ready, 1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 4);
            checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            checkOutput($sformatf("vec%0d_carry", i), cout, vecs[i].co);
            checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
        end
        @(posedge clk); #1;

        // Back-to-back stream: 3-cycle stall mid-stream, then random backpressure
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < NST && cyc < 300) begin
            if (cyc >= 6 && cyc < 9)  out_ready = 1'b0;
            else if (cyc < 12)        out_ready = 1'b1;
            else                      out_ready = 1'($urandom_range(0, 1));
            if (sent < NST) begin
                in_valid = 1'b1; a = sa[sent]; b = sb[sent]; sub = ss[sent]; cin = sc[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checkOutput($sformatf("stream_in_ready@%0d", cyc), in_ready, !(out_valid && !out_ready));
            if (stalled)
                checkOutput($sformatf("stream_hold@%0d", cyc), {out_valid, ovf, cout, sum}, held);
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_result%0d", got), {ovf, cout, sum}, sexp[got]);
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, ovf, cout, sum};
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("stream_count", got, NST);
        in_valid = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        checkOutput("stream_no_duplicate", extra, 0);

        // Reset while three operations are in flight
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + i; b = 32'h1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; rst = 1'b1;
        #1;
        checkOutput("in_ready_during_reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_sum", sum, 0);
        checkOutput("midrst_carry", cout, 0);
        checkOutput("midrst_ovf", ovf, 0);
        extra = 0;
        repeat (8) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_ghost", extra, 0);
        applyStimulus(vecs[2].a, vecs[2].b, vecs[2].s, vecs[2].c, lat);
        checkOutput("postrst_latency", lat, 4);
        checkOutput("postrst_result", {ovf, cout, sum}, {vecs[2].ov, vecs[2].co, vecs[2].sum});

        // Parameter sweep: op e is accepted at edge e and must show up exactly
        // STAGES-1 edges later on each instance
        for (int e = 0; e < NSW + 33; e++) begin
            if (e < NSW) begin
                sw_valid = 1'b1; sw_a = pa[e]; sw_b = pb[e]; sw_sub = ps[e]; sw_cin = pc[e];
            end else begin
                sw_valid = 1'b0;
            end
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) begin
                idx  = e - (SW[g] - 1);
                expv = (idx >= 0) && (idx < NSW);
                checkOutput($sformatf("sweep_s%0d_valid@%0d", SW[g], e), sw_v[g], expv);
                if (expv)
                    checkOutput($sformatf("sweep_s%0d_op%0d", SW[g], idx),
                                {sw_ov[g], sw_c[g], sw_sum[g]},
                                model32(pa[idx], pb[idx], ps[idx], pc[idx]));
            end
            idx  = e - 7;
            expv = (idx >= 0) && (idx < NSW);
            checkOutput($sformatf("sweep_w8_valid@%0d", e), w8_v, expv);
            if (expv)
                checkOutput($sformatf("sweep_w8_op%0d", idx), {w8_ov, w8_c, w8_sum},
                            model8(pa[idx][7:0], pb[idx][7:0], ps[idx], pc[idx]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
